ps2_key_event_ctrl: RTL and testbench

Sequencer that sits behind the PS/2 byte receiver and turns its raw scan-code byte stream (Set 2) into complete key events. It tracks the E0/F0/E1 prefix sequence, maintains modifier-held flags, and buffers events in a small FIFO. The FIFO drains through a valid/ready handshake to the consuming logic (text/display or command path).

---
 rtl/ps2_key_event_ctrl.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_ps2_key_event_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
// Turns the raw PS/2 Set 2 scan-byte stream into complete key events.
// Prefix bytes (E0 extended, F0 release, E1 pause) are folded into a single
// event. Modifier-held flags are tracked as events are decoded. Events are
// buffered in a small first-word-fall-through FIFO, drained by valid/ready.
//
// Optional feature: define PS2_REPEAT_FILTER_EN to suppress typematic
// repeats. A repeated make of the last key made is not queued until that key
// is released or another key is made. Without the macro every make is queued.
//
// Pipeline: a byte sampled at edge N is decoded at edge N (state, modifiers,
// proto_err, repeat filter). The decoded event is written into the FIFO at
// edge N+1. So evt_valid rises one cycle after the decode edge, and overflow
// pulses in the cycle after that FIFO write attempt.

module ps2_key_event_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic       shift_held,
  output logic       ctrl_held,
  output logic       alt_held,
  output logic       overflow,
  output logic       proto_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [7:0] CODE_EXT    = 8'hE0;
  localparam logic [7:0] CODE_BRK    = 8'hF0;
  localparam logic [7:0] CODE_PAUSE  = 8'hE1;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CTRL   = 8'h14;
  localparam logic [7:0] CODE_ALT    = 8'h11;

  // The pause key sends E1 followed by seven more bytes.
  localparam logic [2:0] PAUSE_LAST = 3'd6;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    PAUSE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  pause_cnt;
  logic [2:0]  pause_cnt_nxt;

  // Decoded event for the byte currently on byte_in.
  logic        dec_valid;
  logic [7:0]  dec_code;
  logic        dec_ext;
  logic        dec_brk;
  logic        dec_err;
  logic        dec_suppress;

  // Event waiting for its FIFO write one cycle after decode.
  logic        evt_pend;
  logic [9:0]  evt_pend_data;

  // Modifier flags. Left and right shift are tracked separately.
  logic        lshift_q;
  logic        rshift_q;
  logic        ctrl_q;
  logic        alt_q;

  // FIFO storage and bookkeeping. Each entry is {ext, break, code}.
  logic [9:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_push;
  logic             fifo_pop;
  logic [9:0]       head;

  // A byte that only starts or extends a prefix sequence.
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == CODE_EXT) || (b == CODE_BRK) || (b == CODE_PAUSE);
  endfunction

  // Keyboard status and self-test replies that never form an event.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hFA) ||
           (b == 8'hFC) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  // Prefix-sequence state and pause byte counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pause_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      pause_cnt <= pause_cnt_nxt;
    end
  end

  // Next-state selection from the current prefix context and incoming byte.
  always_comb begin
    state_nxt     = state;
    pause_cnt_nxt = pause_cnt;
    if (byte_valid) begin
      case (state)
        IDLE: begin
          if (byte_in == CODE_EXT) begin
            state_nxt = EXT;
          end else if (byte_in == CODE_BRK) begin
            state_nxt = BRK;
          end else if (byte_in == CODE_PAUSE) begin
            state_nxt     = PAUSE;
            pause_cnt_nxt = 3'd0;
          end
        end
        EXT: begin
          if (byte_in == CODE_BRK) begin
            state_nxt = EXT_BRK;
          end else if (byte_in != CODE_EXT) begin
            state_nxt = IDLE;
          end
        end
        BRK, EXT_BRK: begin
          state_nxt = IDLE;
        end
        PAUSE: begin
          if (pause_cnt == PAUSE_LAST) begin
            state_nxt     = IDLE;
            pause_cnt_nxt = 3'd0;
          end else begin
            pause_cnt_nxt = pause_cnt + 3'd1;
          end
        end
        default: begin
          state_nxt     = IDLE;
          pause_cnt_nxt = 3'd0;
        end
      endcase
    end
  end

  // Event and protocol-error decode for the byte in the current state.
  always_comb begin
    dec_valid = 1'b0;
    dec_code  = byte_in;
    dec_ext   = 1'b0;
    dec_brk   = 1'b0;
    dec_err   = 1'b0;
    if (byte_valid) begin
      case (state)
        IDLE: begin
          dec_valid = !is_prefix(byte_in) && !is_ignored(byte_in);
        end
        EXT: begin
          dec_valid = (byte_in != CODE_BRK) && (byte_in != CODE_EXT);
          dec_ext   = 1'b1;
        end
        BRK: begin
          dec_err   = is_prefix(byte_in);
          dec_valid = !is_prefix(byte_in);
          dec_brk   = 1'b1;
        end
        EXT_BRK: begin
          dec_err   = is_prefix(byte_in);
          dec_valid = !is_prefix(byte_in);
          dec_ext   = 1'b1;
          dec_brk   = 1'b1;
        end
        PAUSE: begin
          dec_valid = (pause_cnt == PAUSE_LAST);
          dec_code  = CODE_PAUSE;
        end
        default: begin
          dec_valid = 1'b0;
        end
      endcase
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic [8:0] last_make_key;
  logic       last_make_valid;

  assign dec_suppress = dec_valid && !dec_brk && last_make_valid &&
                        (last_make_key == {dec_ext, dec_code});

  // Remember the most recent make so a held key's repeats can be dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_make_key   <= 9'd0;
      last_make_valid <= 1'b0;
    end else if (dec_valid) begin
      if (!dec_brk) begin
        last_make_key   <= {dec_ext, dec_code};
        last_make_valid <= 1'b1;
      end else if (last_make_key == {dec_ext, dec_code}) begin
        last_make_valid <= 1'b0;
      end
    end
  end
`else
  assign dec_suppress = 1'b0;
`endif

  // Stage the decoded event for its FIFO write and register the error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_pend      <= 1'b0;
      evt_pend_data <= 10'd0;
      proto_err     <= 1'b0;
    end else begin
      evt_pend      <= dec_valid && !dec_suppress;
      evt_pend_data <= {dec_ext, dec_brk, dec_code};
      proto_err     <= dec_err;
    end
  end

  // Modifier flags follow every decoded event, queued or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      ctrl_q   <= 1'b0;
      alt_q    <= 1'b0;
    end else if (dec_valid) begin
      if (!dec_ext && (dec_code == CODE_LSHIFT)) begin
        lshift_q <= !dec_brk;
      end
      if (!dec_ext && (dec_code == CODE_RSHIFT)) begin
        rshift_q <= !dec_brk;
      end
      if (dec_code == CODE_CTRL) begin
        ctrl_q <= !dec_brk;
      end
      if (dec_code == CODE_ALT) begin
        alt_q <= !dec_brk;
      end
    end
  end

  assign shift_held = lshift_q || rshift_q;
  assign ctrl_held  = ctrl_q;
  assign alt_held   = alt_q;

  // A pop in the same cycle frees the slot, so a write into a full FIFO
  // still succeeds when the consumer takes the head at the same edge.
  assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
  assign evt_valid = (count != '0);
  assign fifo_pop  = evt_valid && evt_ready;
  assign fifo_push = evt_pend && (!fifo_full || fifo_pop);
  assign head      = fifo_mem[rd_ptr];

  // Zero the head fields while empty so nothing stale reaches the consumer.
  assign evt_code  = evt_valid ? head[7:0] : 8'h00;
  assign evt_break = evt_valid ? head[8]   : 1'b0;
  assign evt_ext   = evt_valid ? head[9]   : 1'b0;

  // FIFO storage, pointers, occupancy and the dropped-event pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= 10'd0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= evt_pend && fifo_full && !fifo_pop;
      if (fifo_push) begin
        fifo_mem[wr_ptr] <= evt_pend_data;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb_ps2_key_event_ctrl
// Scoreboard bench for ps2_key_event_ctrl. A behavioural model of the
// scan-code rules fills a queue of expected events. A separate monitor pops
// and compares whenever the DUT hands over an event. Honours
// PS2_REPEAT_FILTER_EN the same way as the design.

module tb_ps2_key_event_ctrl;

  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic       shift_held;
  logic       ctrl_held;
  logic       alt_held;
  logic       overflow;
  logic       proto_err;

  ps2_key_event_ctrl #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .evt_code   (evt_code),
    .evt_ext    (evt_ext),
    .evt_break  (evt_break),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .shift_held (shift_held),
    .ctrl_held  (ctrl_held),
    .alt_held   (alt_held),
    .overflow   (overflow),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_mismatched = 0;

  // Expected events as {ext, break, code}.
  logic [9:0] exp_q[$];
  int exp_overflow = 0;
  int seen_overflow = 0;
  int exp_proto = 0;
  int seen_proto = 0;

  // Reference model: pending prefix flags and bytes left in a pause sequence.
  bit m_ext;
  bit m_brk;
  int m_pause_left;
  bit m_lshift, m_rshift, m_ctrl, m_alt;
  // While the consumer is stalled, at most FIFO_DEPTH events can be held.
  bit m_stalled;
  int m_stall_cnt;
  bit random_ready;
`ifdef PS2_REPEAT_FILTER_EN
  bit [8:0] m_last;
  bit       m_last_v;
`endif

  task automatic check_value(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_pause_left = 0;
    m_lshift = 0; m_rshift = 0; m_ctrl = 0; m_alt = 0;
    m_stalled = 0; m_stall_cnt = 0;
`ifdef PS2_REPEAT_FILTER_EN
    m_last = '0; m_last_v = 0;
`endif
    exp_q.delete();
  endtask

  // A complete key event: refresh modifiers, filter repeats, then queue it.
  task automatic emit(input logic [7:0] code, input bit ext, input bit brk);
    if (code == 8'h12 && !ext) m_lshift = !brk;
    if (code == 8'h59 && !ext) m_rshift = !brk;
    if (code == 8'h14) m_ctrl = !brk;
    if (code == 8'h11) m_alt = !brk;
`ifdef PS2_REPEAT_FILTER_EN
    if (!brk) begin
      if (m_last_v && m_last == {ext, code}) return;
      m_last = {ext, code};
      m_last_v = 1;
    end else if (m_last_v && m_last == {ext, code}) begin
      m_last_v = 0;
    end
`endif
    if (m_stalled) begin
      if (m_stall_cnt >= FIFO_DEPTH) begin
        exp_overflow++;
        return;
      end
      m_stall_cnt++;
    end
    exp_q.push_back({ext, brk, code});
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_pause_left > 0) begin
      m_pause_left--;
      if (m_pause_left == 0) emit(8'hE1, 0, 0);
    end else if (m_brk) begin
      if (b inside {8'hE0, 8'hF0, 8'hE1}) exp_proto++;
      else emit(b, m_ext, 1);
      m_ext = 0; m_brk = 0;
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b != 8'hE0) begin
        emit(b, 1, 0);
        m_ext = 0;
      end
    end else begin
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE1) m_pause_left = 7;
      else if (!(b inside {8'h00, 8'hAA, 8'hFA, 8'hFC, 8'hFE, 8'hFF})) emit(b, 0, 0);
    end
  endtask

  task automatic check_output();
    check_value("shift_held", shift_held, m_lshift | m_rshift);
    check_value("ctrl_held", ctrl_held, m_ctrl);
    check_value("alt_held", alt_held, m_alt);
  endtask

  // Present one byte for one cycle; returns just after the sampling edge.
  task automatic apply_stimulus(input logic [7:0] b);
    byte_in = b;
    byte_valid = 1'b1;
    if (random_ready) evt_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    byte_valid = 1'b0;
    model_byte(b);
    check_output();
  endtask

  task automatic drain();
    int i;
    evt_ready = 1'b1;
    for (i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL drain_timeout: %0d events still expected, got none", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    check_value("drain_empty", evt_valid, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: just before each rising edge, score any accepted head event.
  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL evt_unexpected: got %0h, expected no event",
                   {evt_ext, evt_break, evt_code});
        end else begin
          check_value("evt_head", {evt_ext, evt_break, evt_code}, exp_q.pop_front());
        end
      end
      if (overflow) seen_overflow++;
      if (proto_err) seen_proto++;
    end
  end

  logic [7:0] seq_a [] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h12, 8'hF0, 8'h12};
  logic [7:0] seq_o [] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34};
  logic [7:0] seq_p [] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
  logic [7:0] seq_f [] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
  logic [7:0] ign   [] = '{8'h00, 8'hAA, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

  initial begin
    model_reset();
    random_ready = 0;
    repeat (3) @(negedge clk);
    check_value("rst_evt_valid", evt_valid, 1'b0);
    check_value("rst_evt_code", evt_code, 8'h00);
    check_value("rst_evt_ext", evt_ext, 1'b0);
    check_value("rst_evt_break", evt_break, 1'b0);
    check_value("rst_overflow", overflow, 1'b0);
    check_value("rst_proto_err", proto_err, 1'b0);
    check_output();
    rst_n = 1'b1;
    @(negedge clk);
    evt_ready = 1'b1;

    // Make then break of 1C, checking one-cycle latency each time.
    apply_stimulus(8'h1C);
    check_value("lat_make_early", evt_valid, 1'b0);
    @(negedge clk);
    check_value("lat_make", evt_valid, 1'b1);
    drain();
    apply_stimulus(8'hF0);
    check_value("prefix_no_event", evt_valid, 1'b0);
    apply_stimulus(8'h1C);
    check_value("lat_break_early", evt_valid, 1'b0);
    @(negedge clk);
    check_value("lat_break", evt_valid, 1'b1);
    drain();

    // Extended make/break and left shift press/release.
    foreach (seq_a[i]) apply_stimulus(seq_a[i]);
    drain();

    // Stalled consumer: four buffered, the fifth overflows.
    evt_ready = 1'b0;
    m_stalled = 1;
    m_stall_cnt = 0;
    foreach (seq_o[i]) apply_stimulus(seq_o[i]);
    repeat (2) @(negedge clk);
    check_value("ovf_pulse_count", seen_overflow, exp_overflow);
    check_value("ovf_full_valid", evt_valid, 1'b1);
    // Push and pop in the same cycle while full.
    m_stalled = 0;
    apply_stimulus(8'h1D);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_value("ovf_pushpop_count", seen_overflow, exp_overflow);
    drain();

    // Illegal prefix sequence, then recovery.
    apply_stimulus(8'hF0);
    apply_stimulus(8'hE0);
    @(negedge clk);
    check_value("proto_pulse_count", seen_proto, exp_proto);
    apply_stimulus(8'h1C);
    drain();

    // Ignored status bytes produce nothing.
    foreach (ign[i]) apply_stimulus(ign[i]);
    drain();

    // Pause sequence collapses to a single E1 event.
    foreach (seq_p[i]) apply_stimulus(seq_p[i]);
    drain();

    // Reset in the middle of an extended sequence.
    apply_stimulus(8'hE0);
    do_reset();
    evt_ready = 1'b1;
    apply_stimulus(8'h1C);
    drain();

    // Typematic repeats then release.
    do_reset();
    foreach (seq_f[i]) apply_stimulus(seq_f[i]);
    drain();

    // Randomized traffic with a randomly stalling consumer.
    random_ready = 1;
    for (int n = 0; n < 400; n++) begin
      logic [7:0] b;
      int guard;
      guard = 0;
      while (exp_q.size() >= FIFO_DEPTH && guard < 200) begin
        evt_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL rand_stall_timeout: got no progress, expected consumer to drain");
        exp_q.delete();
      end
      case ($urandom_range(0, 15))
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4:       b = 8'h12;
        5:       b = 8'h59;
        6:       b = 8'h14;
        7:       b = 8'h11;
        8:       b = ign[$urandom_range(0, 5)];
        9:       b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h1C;
        default: b = 8'($urandom_range(1, 8'h83));
      endcase
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      apply_stimulus(b);
    end
    random_ready = 0;
    drain();
    check_value("final_overflow_count", seen_overflow, exp_overflow);
    check_value("final_proto_count", seen_proto, exp_proto);
    check_value("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
